// File: rtl/freq_entry_ctrl.sv
// -----------------------------------------------------------------------------
// freq_entry_ctrl
//
// Keypad front end for a waveform generator. A raw keypad "hit" flag is
// synchronised and debounced into single key events. These events build a
// decimal frequency (up to MAX_DIGITS BCD digits) and a pending waveform. On
// '#' the BCD entry is converted to binary over four cycles. The result is then
// offered to the generator with a valid/ready handshake.
//
// Ports
//   FPGA_CLK1_50  in   1   sole clock, rising edge
//   reset         in   1   asynchronous active-high reset
//   kphit         in   1   raw key-pressed flag (asynchronous)
//   kpval         in   4   key code: 0-9 digit, A-D waveform, E '*', F '#'
//   cfg_ready     in   1   generator accepts configuration
//   cfg_valid     out  1   configuration offer
//   cfg_freq      out  14  binary frequency 1-9999
//   cfg_wave      out  2   waveform select A=0 .. D=3
//   entry_bcd     out  16  digits entered so far, LSD in [3:0]
//   digit_count   out  3   number of digits held in entry_bcd
//   busy          out  1   converting or offering a configuration
//   err           out  1   sticky invalid-entry flag
// -----------------------------------------------------------------------------
module freq_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS      = 4
) (
    input  logic        FPGA_CLK1_50,
    input  logic        reset,
    input  logic        kphit,
    input  logic [3:0]  kpval,
    input  logic        cfg_ready,
    output logic        cfg_valid,
    output logic [13:0] cfg_freq,
    output logic [1:0]  cfg_wave,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value meaning "this cycle completes the debounce period".
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);
    localparam logic [CW-1:0] DB_ZERO = CW'(0);
    localparam logic [2:0]    MAX_DG  = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {K_IDLE, K_PRESS, K_HELD, K_RELEASE} key_state_e;
    typedef enum logic [1:0] {E_ENTRY, E_CONVERT, E_ISSUE} ent_state_e;

    logic          sync1_q, sync2_q;
    key_state_e    key_state_q, key_state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          key_fire_s;
    logic          key_evt_q;
    logic [3:0]    key_code_q, key_code_d;

    ent_state_e    ent_state_q, ent_state_d;
    logic [15:0]   entry_bcd_q, entry_bcd_d;
    logic [2:0]    digit_count_q, digit_count_d;
    logic [1:0]    wave_pend_q, wave_pend_d;
    logic [13:0]   acc_q, acc_d;
    logic [1:0]    idx_q, idx_d;
    logic          cfg_valid_q, cfg_valid_d;
    logic [13:0]   cfg_freq_q, cfg_freq_d;
    logic [1:0]    cfg_wave_q, cfg_wave_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [3:0]    nib_s;
    logic [13:0]   acc_mac_s;

    // Debounce FSM: the counter holds the number of consecutive qualifying
    // cycles already seen, so the DEBOUNCE_CYCLES-th one matches DB_LAST.
    always_comb begin
        key_state_d = key_state_q;
        db_cnt_d    = db_cnt_q;
        key_fire_s  = 1'b0;
        case (key_state_q)
            K_IDLE, K_PRESS: begin
                if (sync2_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        key_fire_s  = 1'b1;
                        key_state_d = K_HELD;
                        db_cnt_d    = DB_ZERO;
                    end else begin
                        key_state_d = K_PRESS;
                        db_cnt_d    = db_cnt_q + DB_ONE;
                    end
                end else begin
                    key_state_d = K_IDLE;
                    db_cnt_d    = DB_ZERO;
                end
            end
            K_HELD, K_RELEASE: begin
                if (!sync2_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        key_state_d = K_IDLE;
                        db_cnt_d    = DB_ZERO;
                    end else begin
                        key_state_d = K_RELEASE;
                        db_cnt_d    = db_cnt_q + DB_ONE;
                    end
                end else begin
                    key_state_d = K_HELD;
                    db_cnt_d    = DB_ZERO;
                end
            end
            default: begin
                key_state_d = K_IDLE;
                db_cnt_d    = DB_ZERO;
            end
        endcase
        // kpval is stable by the time a press has been debounced.
        if (key_fire_s) begin
            key_code_d = kpval;
        end else begin
            key_code_d = key_code_q;
        end
    end

    // Select the BCD nibble for the current conversion step, MSD first.
    always_comb begin
        case (idx_q)
            2'd0:    nib_s = entry_bcd_q[15:12];
            2'd1:    nib_s = entry_bcd_q[11:8];
            2'd2:    nib_s = entry_bcd_q[7:4];
            2'd3:    nib_s = entry_bcd_q[3:0];
            default: nib_s = 4'd0;
        endcase
        // acc never exceeds 999 before the last step, so 14 bits suffice.
        acc_mac_s = acc_q * 14'd10 + {10'd0, nib_s};
    end

    // Entry FSM: digit collection, BCD-to-binary conversion and handshake.
    always_comb begin
        ent_state_d   = ent_state_q;
        entry_bcd_d   = entry_bcd_q;
        digit_count_d = digit_count_q;
        wave_pend_d   = wave_pend_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        cfg_valid_d   = cfg_valid_q;
        cfg_freq_d    = cfg_freq_q;
        cfg_wave_d    = cfg_wave_q;
        err_d         = err_q;
        case (ent_state_q)
            E_ENTRY: begin
                if (key_evt_q) begin
                    if (key_code_q <= 4'd9) begin
                        if (digit_count_q < MAX_DG) begin
                            entry_bcd_d   = {entry_bcd_q[11:0], key_code_q};
                            digit_count_d = digit_count_q + 3'd1;
                            err_d         = 1'b0;
                        end else begin
                            entry_bcd_d = entry_bcd_q;
                        end
                    end else if (key_code_q <= 4'hD) begin
                        wave_pend_d = 2'(key_code_q - 4'hA);
                    end else if (key_code_q == 4'hE) begin
                        entry_bcd_d   = 16'd0;
                        digit_count_d = 3'd0;
                        err_d         = 1'b0;
                    end else begin
                        if ((digit_count_q == 3'd0) || (entry_bcd_q == 16'd0)) begin
                            err_d         = 1'b1;
                            entry_bcd_d   = 16'd0;
                            digit_count_d = 3'd0;
                        end else begin
                            ent_state_d = E_CONVERT;
                            acc_d       = 14'd0;
                            idx_d       = 2'd0;
                        end
                    end
                end else begin
                    ent_state_d = E_ENTRY;
                end
            end
            E_CONVERT: begin
                acc_d = acc_mac_s;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    ent_state_d = E_ISSUE;
                    cfg_valid_d = 1'b1;
                    cfg_freq_d  = acc_mac_s;
                    cfg_wave_d  = wave_pend_q;
                end else begin
                    ent_state_d = E_CONVERT;
                end
            end
            E_ISSUE: begin
                if (cfg_ready) begin
                    cfg_valid_d   = 1'b0;
                    entry_bcd_d   = 16'd0;
                    digit_count_d = 3'd0;
                    ent_state_d   = E_ENTRY;
                end else begin
                    ent_state_d = E_ISSUE;
                end
            end
            default: begin
                ent_state_d = E_ENTRY;
                cfg_valid_d = 1'b0;
            end
        endcase
        busy_d = (ent_state_d == E_CONVERT) || (ent_state_d == E_ISSUE);
    end

    // State registers for synchroniser, debouncer and entry path.
    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            key_state_q   <= K_IDLE;
            db_cnt_q      <= DB_ZERO;
            key_evt_q     <= 1'b0;
            key_code_q    <= 4'd0;
            ent_state_q   <= E_ENTRY;
            entry_bcd_q   <= 16'd0;
            digit_count_q <= 3'd0;
            wave_pend_q   <= 2'd0;
            acc_q         <= 14'd0;
            idx_q         <= 2'd0;
            cfg_valid_q   <= 1'b0;
            cfg_freq_q    <= 14'd0;
            cfg_wave_q    <= 2'd0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            sync1_q       <= kphit;
            sync2_q       <= sync1_q;
            key_state_q   <= key_state_d;
            db_cnt_q      <= db_cnt_d;
            key_evt_q     <= key_fire_s;
            key_code_q    <= key_code_d;
            ent_state_q   <= ent_state_d;
            entry_bcd_q   <= entry_bcd_d;
            digit_count_q <= digit_count_d;
            wave_pend_q   <= wave_pend_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            cfg_valid_q   <= cfg_valid_d;
            cfg_freq_q    <= cfg_freq_d;
            cfg_wave_q    <= cfg_wave_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign cfg_valid   = cfg_valid_q;
    assign cfg_freq    = cfg_freq_q;
    assign cfg_wave    = cfg_wave_q;
    assign entry_bcd   = entry_bcd_q;
    assign digit_count = digit_count_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_freq_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_entry_ctrl
//
// Bench for freq_entry_ctrl with a short debounce period. A behavioural model
// tracks the entered digits as a list of integers, computes the frequency with
// decimal arithmetic and times the offer with a countdown. It is compared
// against the design every cycle. Directed scenarios pin the model with
// hand-computed values; a randomized key stream follows.
// -----------------------------------------------------------------------------
module tb_freq_entry_ctrl;

    localparam int D    = 4;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        kphit;
    logic [3:0]  kpval;
    logic        cfg_ready;
    logic        cfg_valid;
    logic [13:0] cfg_freq;
    logic [1:0]  cfg_wave;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic        busy;
    logic        err;

    freq_entry_ctrl #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAXD)) dut (
        .FPGA_CLK1_50(clk),
        .reset       (reset),
        .kphit       (kphit),
        .kpval       (kpval),
        .cfg_ready   (cfg_ready),
        .cfg_valid   (cfg_valid),
        .cfg_freq    (cfg_freq),
        .cfg_wave    (cfg_wave),
        .entry_bcd   (entry_bcd),
        .digit_count (digit_count),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit         m_s1, m_s2;        // kphit as seen after two clock delays
    bit         m_pressed;         // debounced key level
    int         m_run;             // consecutive cycles disagreeing with m_pressed
    bit         m_evt;             // key event visible to the entry logic next edge
    logic [3:0] m_code;
    int         m_digits[$];
    int         m_wave_pend;
    int         m_phase;           // 0 entry, 1 converting, 2 offering
    int         m_conv_left;
    int         m_pending_freq;
    bit         m_valid;
    int         m_freq;
    int         m_wave;
    bit         m_err;

    int  ready_mode = 0;           // 0 low, 1 high, 2 random
    bit  cmp_en = 1'b0;
    int  vrun = 0;
    int  last_vlen = 0;
    int  nvalid = 0;
    bit  prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_bcd();
        logic [15:0] b;
        b = 16'd0;
        foreach (m_digits[i]) b = {b[11:0], 4'(m_digits[i])};
        return b;
    endfunction

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_pressed = 1'b0; m_run = 0; m_evt = 1'b0;
        m_code = 4'd0; m_digits.delete(); m_wave_pend = 0; m_phase = 0;
        m_conv_left = 0; m_pending_freq = 0; m_valid = 1'b0; m_freq = 0;
        m_wave = 0; m_err = 1'b0;
    endtask

    task automatic apply_key(input int code);
        int value;
        if (code <= 9) begin
            if (m_digits.size() < MAXD) begin
                m_digits.push_back(code);
                m_err = 1'b0;
            end
        end else if (code <= 13) begin
            m_wave_pend = code - 10;
        end else if (code == 14) begin
            m_digits.delete();
            m_err = 1'b0;
        end else begin
            value = 0;
            foreach (m_digits[i]) value = value * 10 + m_digits[i];
            if (m_digits.size() == 0 || value == 0) begin
                m_err = 1'b1;
                m_digits.delete();
            end else begin
                m_phase = 1;
                m_conv_left = 4;
                m_pending_freq = value;
            end
        end
    endtask

    // One rising edge of the model, using the inputs held before the edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            if (m_evt) apply_key(int'(m_code));
        end else if (m_phase == 1) begin
            m_conv_left--;
            if (m_conv_left == 0) begin
                m_phase = 2;
                m_valid = 1'b1;
                m_freq  = m_pending_freq;
                m_wave  = m_wave_pend;
            end
        end else begin
            if (cfg_ready) begin
                m_valid = 1'b0;
                m_digits.delete();
                m_phase = 0;
            end
        end
        m_evt = 1'b0;
        if (m_s2 != m_pressed) begin
            m_run++;
            if (m_run == D) begin
                if (!m_pressed) begin
                    m_evt  = 1'b1;
                    m_code = kpval;
                end
                m_pressed = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = kphit;
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !reset) begin
                chk("cfg_valid", cfg_valid, m_valid);
                chk("cfg_freq", cfg_freq, m_freq);
                chk("cfg_wave", cfg_wave, m_wave);
                chk("entry_bcd", entry_bcd, m_bcd());
                chk("digit_count", digit_count, m_digits.size());
                chk("busy", busy, m_phase != 0);
                chk("err", err, m_err);
            end
            if (cfg_valid) begin
                vrun++;
                if (!prev_valid) nvalid++;
            end else if (vrun > 0) begin
                last_vlen = vrun;
                vrun = 0;
            end
            prev_valid = cfg_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        case (ready_mode)
            0:       cfg_ready = 1'b0;
            1:       cfg_ready = 1'b1;
            default: cfg_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [3:0] code, input int hi);
        kpval = code;
        kphit = 1'b1;
        repeat (hi) step();
        kphit = 1'b0;
    endtask

    task automatic key(input logic [3:0] code);
        press(code, 8);
        gap(8);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!cfg_valid && n < 60) begin
            step();
            n++;
        end
        if (!cfg_valid) chk("valid_timeout", cfg_valid, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, cfg_valid, 0);
        chk({tag, "_freq"}, cfg_freq, 0);
        chk({tag, "_wave"}, cfg_wave, 0);
        chk({tag, "_bcd"}, entry_bcd, 0);
        chk({tag, "_cnt"}, digit_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Assert reset between clock edges and check it acts without a clock.
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values(tag);
        step();
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] pat;
        int nv;
        int r;
        logic [3:0] code;
        reset = 1'b1; kphit = 1'b0; kpval = 4'd0; cfg_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;
        cmp_en = 1'b1;

        // 1,2,5,0,# with ready held high: single-cycle offer of 1250 / A.
        ready_mode = 1;
        key(4'd1); key(4'd2); key(4'd5); key(4'd0);
        press(4'hF, 8);
        gap(20);
        chk("s1_freq", cfg_freq, 1250);
        chk("s1_wave", cfg_wave, 0);
        chk("s1_vlen", last_vlen, 1);
        chk("s1_bcd", entry_bcd, 0);

        // C,9,# with ready low for 10 offer cycles: offer lasts 11 cycles.
        ready_mode = 0;
        key(4'hC); key(4'd9);
        press(4'hF, 8);
        wait_valid();
        repeat (9) step();
        ready_mode = 1;
        step();
        ready_mode = 0;
        gap(5);
        chk("s2_vlen", last_vlen, 11);
        chk("s2_freq", cfg_freq, 9);
        chk("s2_wave", cfg_wave, 2);

        // Short press and bounce produce no key; a clean press gives one.
        key(4'hE);
        press(4'd5, 3);
        gap(10);
        chk("short_cnt", digit_count, 0);
        pat = 16'b1101110101110110;
        kpval = 4'd6;
        for (int i = 0; i < 16; i++) begin
            kphit = pat[i];
            step();
        end
        kphit = 1'b0;
        gap(10);
        chk("bounce_cnt", digit_count, 0);
        key(4'd7);
        chk("clean_cnt", digit_count, 1);
        chk("clean_bcd", entry_bcd, 16'h0007);

        // Fifth digit ignored; 9876 converts correctly.
        key(4'hE);
        key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5);
        chk("full_bcd", entry_bcd, 16'h9876);
        chk("full_cnt", digit_count, 4);
        ready_mode = 1;
        press(4'hF, 8);
        gap(20);
        chk("full_freq", cfg_freq, 9876);

        // Empty and all-zero entries flag err and never offer.
        nv = nvalid;
        key(4'hF);
        chk("empty_err", err, 1);
        key(4'd0); key(4'd0); key(4'hF);
        chk("zero_err", err, 1);
        chk("zero_cnt", digit_count, 0);
        chk("no_offer", nvalid, nv);

        // Key while offering is ignored; reset aborts the offer.
        ready_mode = 0;
        key(4'd4); key(4'd2);
        press(4'hF, 8);
        wait_valid();
        key(4'd3);
        chk("issue_bcd", entry_bcd, 16'h0042);
        chk("issue_valid", cfg_valid, 1);
        reset_pulse("abort");
        gap(10);

        // Randomized key stream with random handshake and occasional reset.
        ready_mode = 2;
        repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 60)      code = 4'($urandom_range(0, 9));
            else if (r < 70) code = 4'($urandom_range(10, 13));
            else if (r < 78) code = 4'hE;
            else             code = 4'hF;
            press(code, $urandom_range(1, 10));
            gap($urandom_range(1, 10));
            if ($urandom_range(0, 49) == 0) reset_pulse("rnd_rst");
        end
        kphit = 1'b0;
        gap(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
